// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic              p1_err;

    logic [DATA_W-1:0] rdata;
    logic [7:0]        err_count;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_to_write;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_memory_output;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_memory_output,
        output p0_gnt, p0_rvalid, p0_err,
        output p1_gnt, p1_rvalid, p1_err,
        output rdata, err_count,
        output mem_address, mem_data_to_write, mem_write_enable
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_memory_output,
        input  p0_gnt, p0_rvalid, p0_err,
        input  p1_gnt, p1_rvalid, p1_err,
        input  rdata, err_count,
        input  mem_address, mem_data_to_write, mem_write_enable
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter for the shared data memory port: combinational grant and command,
// one-cycle read response tracking, and rejection of misaligned accesses.
module data_memory_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    data_memory_arbiter_if.slave bus
);

    typedef enum logic {
        RESP_IDLE = 1'b0,
        RESP_READ = 1'b1
    } resp_state_t;

    resp_state_t       r_state;
    resp_state_t       w_state_next;
    logic              r_last;
    logic              r_resp_port;
    logic              r_err_pend;
    logic              r_err_port;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_data_hold;
    logic [7:0]        r_err_count;

    logic              w_any;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misaligned;
    logic              w_fwd;
    logic              w_read_issue;
    logic              w_p0_rvalid;
    logic              w_p1_rvalid;

    // On a tie the port that did not win last time is selected.
    assign w_any  = bus.p0_req | bus.p1_req;
    assign w_sel  = (bus.p0_req & bus.p1_req) ? ~r_last : bus.p1_req;

    assign w_we    = w_sel ? bus.p1_we    : bus.p0_we;
    assign w_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
    assign w_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;

    assign w_misaligned = |w_addr[1:0];
    assign w_fwd        = w_any & ~w_misaligned;
    assign w_read_issue = w_fwd & ~w_we;

    assign bus.p0_gnt = w_any & ~w_sel;
    assign bus.p1_gnt = w_any &  w_sel;

    // Rejected and idle cycles present the holding registers so the memory sees a stable address.
    assign bus.mem_write_enable  = w_fwd & w_we;
    assign bus.mem_address       = w_fwd ? w_addr  : r_addr_hold;
    assign bus.mem_data_to_write = w_fwd ? w_wdata : r_data_hold;

    assign bus.rdata     = bus.mem_memory_output;
    assign bus.err_count = r_err_count;
    assign bus.p0_err    = r_err_pend & ~r_err_port;
    assign bus.p1_err    = r_err_pend &  r_err_port;
    assign bus.p0_rvalid = w_p0_rvalid;
    assign bus.p1_rvalid = w_p1_rvalid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = RESP_IDLE;
        w_p0_rvalid  = 1'b0;
        w_p1_rvalid  = 1'b0;
        case (r_state)
            RESP_IDLE: ;
            RESP_READ: begin
                w_p0_rvalid = ~r_resp_port;
                w_p1_rvalid =  r_resp_port;
            end
            default: ;
        endcase
        if (w_read_issue) begin
            w_state_next = RESP_READ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last      <= 1'b1;
            r_resp_port <= 1'b0;
            r_err_pend  <= 1'b0;
            r_err_port  <= 1'b0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
            r_err_count <= 8'd0;
        end else begin
            r_err_pend <= w_any & w_misaligned;
            if (w_any) begin
                r_last <= w_sel;
            end
            if (w_read_issue) begin
                r_resp_port <= w_sel;
            end
            if (w_any & w_misaligned) begin
                r_err_port <= w_sel;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (w_fwd) begin
                r_addr_hold <= w_addr;
                r_data_hold <= w_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a transaction-level model predicts grants,
// memory commands and responses; a monitor compares the response pins every cycle.
module tb_data_memory_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef struct {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        bit          port;
        bit          is_err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory with a registered read port.
    logic [31:0] env_mem [64];
    logic [31:0] env_q;
    always @(posedge clk) begin
        if (bus.mem_write_enable) env_mem[bus.mem_address[7:2]] <= bus.mem_data_to_write;
        env_q <= env_mem[bus.mem_address[7:2]];
    end
    assign bus.mem_memory_output = env_q;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_vec = 0;
    int n_bad = 0;
    resp_t sb[$];

    // Reference state at transaction level.
    logic [31:0] ref_mem [64];
    bit          m_last;
    logic [7:0]  m_hold_addr;
    logic [31:0] m_hold_data;
    int          m_errcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        req_t r;
        r.req = 1'b1; r.we = we; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        logic [5:0] w;
        logic [7:0] a;
        w = 6'($urandom_range(0, 63));
        a = {w, 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return mk(1'($urandom_range(0, 1)), a, $urandom);
    endfunction

    req_t idle;
    initial begin
        idle.req = 1'b0; idle.we = 1'b0; idle.addr = '0; idle.wdata = '0;
    end

    task automatic model_reset();
        m_last = 1'b1;
        m_hold_addr = '0;
        m_hold_data = '0;
        m_errcnt = 0;
        sb.delete();
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        bus.p0_req = r0.req; bus.p0_we = r0.we; bus.p0_addr = r0.addr; bus.p0_wdata = r0.wdata;
        bus.p1_req = r1.req; bus.p1_we = r1.we; bus.p1_addr = r1.addr; bus.p1_wdata = r1.wdata;
    endtask

    // One clock cycle: apply both requests, check grant and memory command, predict responses.
    task automatic step(input req_t r0, input req_t r1, output int win);
        logic [1:0] exp_gnt;
        req_t       g;
        resp_t      e;
        @(posedge clk);
        #1;
        drive(r0, r1);
        @(negedge clk);
        win = -1;
        if (r0.req && r1.req) win = m_last ? 0 : 1;
        else if (r0.req)      win = 0;
        else if (r1.req)      win = 1;
        exp_gnt = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
        check("gnt", 32'({bus.p1_gnt, bus.p0_gnt}), 32'(exp_gnt));
        check("err_count", 32'(bus.err_count), 32'(m_errcnt));
        g = (win == 1) ? r1 : r0;
        if (win >= 0 && g.addr[1:0] == 2'b00) begin
            check("mem_we", 32'(bus.mem_write_enable), 32'(g.we));
            check("mem_addr", 32'(bus.mem_address), 32'(g.addr));
            check("mem_wdata", bus.mem_data_to_write, g.wdata);
            m_hold_addr = g.addr;
            m_hold_data = g.wdata;
            if (g.we) begin
                ref_mem[g.addr[7:2]] = g.wdata;
            end else begin
                e.due = cycle + 1; e.port = (win == 1); e.is_err = 1'b0; e.data = ref_mem[g.addr[7:2]];
                sb.push_back(e);
            end
        end else begin
            check("mem_we_idle", 32'(bus.mem_write_enable), 32'd0);
            check("mem_addr_hold", 32'(bus.mem_address), 32'(m_hold_addr));
            check("mem_wdata_hold", bus.mem_data_to_write, m_hold_data);
            if (win >= 0) begin
                e.due = cycle + 1; e.port = (win == 1); e.is_err = 1'b1; e.data = '0;
                sb.push_back(e);
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        if (win >= 0) m_last = (win == 1);
    endtask

    // Response monitor: pops whatever the model owes for this cycle, otherwise expects silence.
    always @(negedge clk) begin : monitor
        resp_t      e;
        logic [1:0] exp_rv;
        logic [1:0] exp_er;
        bit         have;
        exp_rv = 2'b00;
        exp_er = 2'b00;
        have   = 1'b0;
        if (sb.size() > 0 && sb[0].due == cycle) begin
            e = sb.pop_front();
            have = 1'b1;
            if (e.is_err) exp_er[e.port] = 1'b1;
            else          exp_rv[e.port] = 1'b1;
        end
        check("rvalid", 32'({bus.p1_rvalid, bus.p0_rvalid}), 32'(exp_rv));
        check("err", 32'({bus.p1_err, bus.p0_err}), 32'(exp_er));
        if (have && !e.is_err) check("rdata", bus.rdata, e.data);
    end

    task automatic check_reset_outputs();
        check("rst_gnt", 32'({bus.p1_gnt, bus.p0_gnt}), 32'd0);
        check("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
        check("rst_mem_wdata", bus.mem_data_to_write, 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
    endtask

    initial begin : main
        int   win;
        req_t r0;
        req_t r1;
        reset = 1'b1;
        drive(idle, idle);
        model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill the whole memory through port 1, then the contention pattern words through port 0.
        for (int i = 0; i < 64; i++) step(idle, mk(1'b1, 8'(i * 4), $urandom), win);
        step(mk(1'b1, 8'h00, 32'h1111_1111), idle, win);
        step(mk(1'b1, 8'h04, 32'h2222_2222), idle, win);

        step(mk(1'b1, 8'h10, 32'hDEAD_BEEF), idle, win);
        step(mk(1'b0, 8'h10, 32'h0), idle, win);
        step(idle, idle, win);

        for (int i = 0; i < 6; i++) step(mk(1'b0, 8'h00, 32'h0), mk(1'b0, 8'h04, 32'h0), win);

        step(idle, mk(1'b0, 8'h08, 32'h0), win);
        step(idle, mk(1'b1, 8'h08, 32'hCAFE_F00D), win);
        step(idle, mk(1'b0, 8'h08, 32'h0), win);

        step(mk(1'b0, 8'h05, 32'h0), idle, win);
        step(idle, mk(1'b1, 8'h03, 32'hBAD0_BAD0), win);
        step(mk(1'b0, 8'h00, 32'h0), idle, win);
        step(idle, idle, win);

        // Randomised traffic: each requester holds its request until granted.
        r0 = idle;
        r1 = idle;
        for (int i = 0; i < 1500; i++) begin
            if (!r0.req && $urandom_range(0, 9) < 6) r0 = rand_req();
            if (!r1.req && $urandom_range(0, 9) < 6) r1 = rand_req();
            step(r0, r1, win);
            if (win == 0) r0.req = 1'b0;
            if (win == 1) r1.req = 1'b0;
        end
        step(r0, r1, win);
        if (win == 0) r0.req = 1'b0;
        if (win == 1) r1.req = 1'b0;
        step(r0, r1, win);
        step(idle, idle, win);

        for (int i = 0; i < 300; i++) begin
            r0 = mk(1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))}, $urandom);
            if ($urandom_range(0, 1) == 0) step(r0, idle, win);
            else                           step(idle, r0, win);
        end
        step(idle, idle, win);
        check("err_count_sat", 32'(bus.err_count), 32'd255);

        // Reset lands in the cycle where the read response would be presented.
        step(mk(1'b0, 8'h10, 32'h0), idle, win);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(idle, idle);
        model_reset();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b0;
        step(mk(1'b0, 8'h00, 32'h0), mk(1'b0, 8'h04, 32'h0), win);
        check("tie_after_reset", 32'(win), 32'd0);
        step(mk(1'b0, 8'h00, 32'h0), mk(1'b0, 8'h04, 32'h0), win);
        step(idle, idle, win);
        step(idle, idle, win);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
